serial_comparator_ctrl: RTL and testbench

SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

---
 rtl/serial_comparator_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_comparator_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - nibble-serial magnitude comparator with cascade inputs
// Optional feature macro: CMP_EARLY_EXIT_EN (MSB-first scan with early exit on first unequal nibble).
// Default build scans LSB-first over all nibbles, carrying a running L/E/G.
module serial_comparator_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   l,
  input  logic                   e,
  input  logic                   g,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   L,
  output logic                   E,
  output logic                   G
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  // Early-exit build: holds the captured cascade-in.
  // Default build: holds the running {L,E,G}, seeded with the cascade-in.
  logic [2:0]      cas_q, cas_d;
  logic [2:0]      res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CW-1:0]   sel;
  logic [3:0]      nib_a, nib_b;
  logic            nib_lt, nib_gt;
  logic [2:0]      step;

  // Nibble being examined this cycle: counter position mapped to MSB-first or LSB-first order
`ifdef CMP_EARLY_EXIT_EN
  assign sel = LAST - cnt_q;
`else
  assign sel = cnt_q;
`endif

  // Single shared 4-bit compare slice fed by a nibble mux
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (sel == CW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    nib_lt = (nib_a < nib_b);
    nib_gt = (nib_a > nib_b);
    if (nib_lt)      step = 3'b100;
    else if (nib_gt) step = 3'b001;
    else             step = cas_q;
  end

  // Next-state, capture and result logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cas_d   = cas_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          cas_d   = {l, e, g};
          cnt_d   = '0;
        end
      end
      S_RUN: begin
`ifdef CMP_EARLY_EXIT_EN
        // First unequal nibble from the top decides; all-equal falls back to cascade-in
        if (nib_lt || nib_gt || (cnt_q == LAST)) begin
          res_d   = step;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        // Higher nibbles override lower ones, so the last unequal nibble seen wins
        cas_d = step;
        if (cnt_q == LAST) begin
          res_d   = step;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cas_q   <= cas_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign {L, E, G}   = res_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// tb/tb_serial_comparator_ctrl.sv - randomized self-checking bench for serial_comparator_ctrl
module tb_serial_comparator_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         l_in, e_in, g_in;
  logic         ready, busy, done;
  logic         lt_o, eq_o, gt_o;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;

  serial_comparator_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .l     (l_in),
    .e     (e_in),
    .g     (g_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .L     (lt_o),
    .E     (eq_o),
    .G     (gt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: magnitude compare, cascade-in only when equal
  function automatic logic [2:0] ref_leg(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] cin);
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return cin;
  endfunction

  // Reference RUN-cycle count
  function automatic int ref_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 1; i <= NIB; i++)
      if (((x >> (4 * (NIB - i))) & 'hF) != ((y >> (4 * (NIB - i))) & 'hF)) return i;
    return NIB;
`else
    return NIB;
`endif
  endfunction

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    start = 1'b0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // One comparison; spam keeps start high with fresh operands while busy
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2:0] tc, input bit spam);
    int n;
    logic [2:0] exp_r;
    wait_ready();
    a_in = ta; b_in = tb_v; {l_in, e_in, g_in} = tc; start = 1'b1;
    exp_r = ref_leg(ta, tb_v, tc);
    done_exp++;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      if (spam) begin
        start = 1'b1;
        a_in = W'($urandom);
        b_in = W'($urandom);
        {l_in, e_in, g_in} = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
    check("latency", 32'(n), 32'(ref_cycles(ta, tb_v)));
    check("leg", {29'd0, lt_o, eq_o, gt_o}, {29'd0, exp_r});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0] rc;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; l_in = 0; e_in = 0; g_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_leg", {29'd0, lt_o, eq_o, gt_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_cmp(16'h1234, 16'h1235, 3'b000, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b010, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b100, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b111, 0);
    run_cmp(16'h9000, 16'h1FFF, 3'b010, 0);
    run_cmp(16'h0001, 16'h0000, 3'b010, 0);
    run_cmp(16'h0000, 16'hFFFF, 3'b001, 1);
    run_cmp(16'h8000, 16'h7FFF, 3'b100, 1);

    // Reset on the second RUN cycle
    wait_ready();
    a_in = 16'h0010; b_in = 16'h0001; {l_in, e_in, g_in} = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_leg", {29'd0, lt_o, eq_o, gt_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_cmp(16'h0010, 16'h0001, 3'b010, 0);

    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
        default: rb = W'($urandom);
      endcase
      rc = 3'($urandom);
      run_cmp(ra, rb, rc, ($urandom_range(0, 3) == 0));
    end

    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    check("done_count", 32'(done_seen), 32'(done_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
